exu_result_arbiter: RTL and testbench



---
 rtl/exu_result_arbiter_pkg.sv | 14 +
 rtl/exu_result_arbiter_result_fifo.sv | 56 +++++
 rtl/exu_result_arbiter.sv | 151 +++++++++++++++
 tb/tb_exu_result_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/exu_result_arbiter_pkg.sv
// Shared types for the execution-stage writeback collector.
package exu_result_arbiter_pkg;

  localparam int unsigned NumFu = 4;

  typedef logic [$clog2(NumFu)-1:0] fu_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rd_we;
  } instr_packet_t;

endpackage

// File: rtl/exu_result_arbiter_result_fifo.sv
// Per-channel result FIFO: packet+result payload, occupancy count and synchronous clear.
module result_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        rdata,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0]   CntFull = (PtrW + 1)'(DEPTH);
  localparam logic [PtrW:0]   CntOne  = (PtrW + 1)'(1);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CntFull);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PtrOne;
      if (do_pop)  rd_ptr <= rd_ptr + PtrOne;
      // Simultaneous push and pop leaves the count unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + CntOne;
        2'b01:   count <= count - CntOne;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/exu_result_arbiter.sv
// Round-robin writeback collector over per-unit result FIFOs with grant lock and flush.
// Define RESULT_BYPASS_EN to let an empty channel's incoming result win in the same cycle.
module exu_result_arbiter
  import exu_result_arbiter_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NUM_FU     = NumFu,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic [NUM_FU-1:0]              fu_valid_i,
  input  logic [NUM_FU-1:0][XLEN-1:0]    fu_result_i,
  input  instr_packet_t [NUM_FU-1:0]     fu_packet_i,
  output logic [NUM_FU-1:0]              fu_ready_o,
  output logic                           wb_valid_o,
  output logic [XLEN-1:0]                wb_result_o,
  output instr_packet_t                  wb_packet_o,
  output logic [$clog2(NUM_FU)-1:0]      wb_fu_id_o,
  input  logic                           wb_ready_i,
  output logic [NUM_FU-1:0]              fifo_full_o
);

  localparam int unsigned IdW  = $clog2(NUM_FU);
  localparam int unsigned PayW = $bits(instr_packet_t) + XLEN;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  logic [NUM_FU-1:0]           full;
  logic [NUM_FU-1:0]           empty;
  logic [NUM_FU-1:0]           push;
  logic [NUM_FU-1:0]           pop;
  logic [NUM_FU-1:0]           req;
  logic [NUM_FU-1:0][PayW-1:0] head;
  logic [NUM_FU-1:0][PayW-1:0] cand;
  logic [NUM_FU-1:0][CntW-1:0] count;
  logic [PayW-1:0]             payload;

  logic           lock_q;
  logic [IdW-1:0] lock_id_q;
  logic [IdW-1:0] rr_ptr_q;
  logic [IdW-1:0] winner;
  logic [IdW-1:0] sel;
  logic [IdW-1:0] next_ptr;
  logic           any_req;
  logic           handshake;

`ifdef RESULT_BYPASS_EN
  logic [NUM_FU-1:0] bypass;

  always_comb begin
    bypass = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      bypass[k] = empty[k] & fu_valid_i[k] & ~lock_q & ~flush_i;
    end
  end
`endif

  always_comb begin
    req  = '0;
    cand = head;
    for (int k = 0; k < NUM_FU; k++) begin
`ifdef RESULT_BYPASS_EN
      req[k] = ~empty[k] | bypass[k];
      if (empty[k]) cand[k] = {fu_packet_i[k], fu_result_i[k]};
`else
      req[k] = ~empty[k];
`endif
    end
  end

  // Scan offsets high to low so the smallest offset from rr_ptr wins.
  always_comb begin
    winner  = rr_ptr_q;
    any_req = 1'b0;
    sel     = '0;
    if (lock_q) begin
      winner  = lock_id_q;
      any_req = 1'b1;
    end else begin
      for (int i = NUM_FU - 1; i >= 0; i--) begin
        sel = IdW'((32'(rr_ptr_q) + 32'(i)) % NUM_FU);
        if (req[sel]) begin
          winner  = sel;
          any_req = 1'b1;
        end
      end
    end
  end

  assign handshake = any_req & wb_ready_i;
  assign next_ptr  = (32'(winner) == NUM_FU - 1) ? '0 : winner + IdW'(1);
  assign payload   = any_req ? cand[winner] : '0;
  assign {wb_packet_o, wb_result_o} = payload;
  assign wb_valid_o  = any_req;
  assign wb_fu_id_o  = any_req ? winner : '0;
  assign fifo_full_o = full;

  always_comb begin
    push       = '0;
    pop        = '0;
    fu_ready_o = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      fu_ready_o[k] = (count[k] != CntFull);
      pop[k]        = handshake & (winner == IdW'(k)) & ~empty[k];
      push[k]       = fu_valid_i[k] & fu_ready_o[k] & ~flush_i;
`ifdef RESULT_BYPASS_EN
      // A bypassed result accepted this cycle never enters its FIFO.
      if (bypass[k] && handshake && winner == IdW'(k)) push[k] = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rr_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      lock_q    <= any_req & ~wb_ready_i;
      lock_id_q <= winner;
      if (handshake) rr_ptr_q <= next_ptr;
    end
  end

  for (genvar k = 0; k < NUM_FU; k++) begin : g_fifo
    result_fifo #(
      .WIDTH(PayW),
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk  (clk_i),
      .rst  (rst_i),
      .clear(flush_i),
      .push (push[k]),
      .pop  (pop[k]),
      .wdata({fu_packet_i[k], fu_result_i[k]}),
      .rdata(head[k]),
      .count(count[k]),
      .full (full[k]),
      .empty(empty[k])
    );
  end

`ifdef ASSERTIONS
  no_push_while_full: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
    (fu_valid_i & ~fu_ready_o) == '0)
    else $error("result dropped: fu_valid_i asserted while channel full");
`endif

endmodule

// File: tb/tb_exu_result_arbiter.sv
// Directed self-checking bench for exu_result_arbiter (default 4 channels, depth 4).
module tb_exu_result_arbiter;
  import exu_result_arbiter_pkg::*;

`ifdef RESULT_BYPASS_EN
  localparam int Lat = 0;
`else
  localparam int Lat = 1;
`endif

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 flush_i;
  logic [3:0]           fu_valid_i;
  logic [3:0][31:0]     fu_result_i;
  instr_packet_t [3:0]  fu_packet_i;
  logic [3:0]           fu_ready_o;
  logic                 wb_valid_o;
  logic [31:0]          wb_result_o;
  instr_packet_t        wb_packet_o;
  logic [1:0]           wb_fu_id_o;
  logic                 wb_ready_i;
  logic [3:0]           fifo_full_o;

  int n_checks = 0;
  int n_pass   = 0;

  exu_result_arbiter #(
    .XLEN(32),
    .NUM_FU(4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .fu_valid_i (fu_valid_i),
    .fu_result_i(fu_result_i),
    .fu_packet_i(fu_packet_i),
    .fu_ready_o (fu_ready_o),
    .wb_valid_o (wb_valid_o),
    .wb_result_o(wb_result_o),
    .wb_packet_o(wb_packet_o),
    .wb_fu_id_o (wb_fu_id_o),
    .wb_ready_i (wb_ready_i),
    .fifo_full_o(fifo_full_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_wb(input string tag, input int id, input logic [31:0] data);
    check({tag, "_valid"}, 64'(wb_valid_o), 64'd1);
    check({tag, "_id"}, 64'(wb_fu_id_o), 64'(id));
    check({tag, "_data"}, 64'(wb_result_o), 64'(data));
    check({tag, "_pc"}, 64'(wb_packet_o.pc), 64'(32'h1000 + data));
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
    fu_valid_i = '0;
    flush_i    = 1'b0;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input int k, input logic [31:0] data);
    fu_valid_i[k]        = 1'b1;
    fu_result_i[k]       = data;
    fu_packet_i[k].pc    = 32'h1000 + data;
    fu_packet_i[k].rd    = 5'(k);
    fu_packet_i[k].rd_we = 1'b1;
  endtask

  initial begin
    rst_i       = 1'b1;
    flush_i     = 1'b0;
    fu_valid_i  = '0;
    fu_result_i = '0;
    fu_packet_i = '0;
    wb_ready_i  = 1'b0;

    // Reset held for two cycles
    next_cycle();
    rst_i = 1'b1;
    next_cycle();
    rst_i = 1'b0;
    settle();
    check("rst_valid", 64'(wb_valid_o), 64'd0);
    check("rst_ready", 64'(fu_ready_o), 64'hf);
    check("rst_full", 64'(fifo_full_o), 64'd0);
    check("rst_id", 64'(wb_fu_id_o), 64'd0);
    check("rst_data", 64'(wb_result_o), 64'd0);
    check("rst_pkt", 64'(wb_packet_o), 64'd0);

    // Round robin: one entry on every channel at once
    for (int c = 0; c <= 4 + Lat; c++) begin
      next_cycle();
      wb_ready_i = 1'b1;
      if (c == 0) for (int k = 0; k < 4; k++) drive(k, 32'hA0 + 32'(k));
      settle();
      if (c - Lat >= 0 && c - Lat <= 3) check_wb("rr", c - Lat, 32'hA0 + 32'(c - Lat));
      else check("rr_idle", 64'(wb_valid_o), 64'd0);
    end

    // Backpressure with a lower-index arrival during the stall
    for (int c = 0; c <= Lat + 7; c++) begin
      next_cycle();
      wb_ready_i = (c >= Lat + 5);
      if (c == 0) drive(2, 32'h55);
      if (c == Lat + 2) drive(0, 32'h99);
      settle();
      if (c >= Lat && c <= Lat + 5) check_wb("bp", 2, 32'h55);
      else if (c == Lat + 6) check_wb("bp_next", 0, 32'h99);
      else check("bp_idle", 64'(wb_valid_o), 64'd0);
    end

    // Fill channel 1, then drain in order
    for (int c = 0; c <= 9; c++) begin
      next_cycle();
      wb_ready_i = (c >= 5);
      if (c <= 3) drive(1, 32'(c + 1));
      settle();
      if (c == 3) check("full_ready3", 64'(fu_ready_o), 64'hf);
      if (c == 4 || c == 5) begin
        check("full_ready", 64'(fu_ready_o), 64'hd);
        check("full_flag", 64'(fifo_full_o), 64'h2);
        check_wb("full_head", 1, 32'd1);
      end
      if (c == 6) begin
        check("full_ready_back", 64'(fu_ready_o), 64'hf);
        check("full_flag_back", 64'(fifo_full_o), 64'h0);
      end
      if (c >= 6 && c <= 8) check_wb("full_order", 1, 32'(c - 4));
      if (c == 9) check("full_idle", 64'(wb_valid_o), 64'd0);
    end

    // Flush with three channels holding two entries each
    for (int c = 0; c <= 8; c++) begin
      next_cycle();
      wb_ready_i = (c >= 4);
      if (c == 0) for (int k = 0; k < 3; k++) drive(k, 32'hC0 + 32'(k));
      if (c == 1) for (int k = 0; k < 3; k++) drive(k, 32'hD0 + 32'(k));
      if (c == 2) begin
        flush_i = 1'b1;
        drive(0, 32'hEE);
      end
      settle();
      if (c == 2) check("fl_pre", 64'(wb_valid_o), 64'd1);
      if (c == 3) begin
        check("fl_ready", 64'(fu_ready_o), 64'hf);
        check("fl_full", 64'(fifo_full_o), 64'd0);
      end
      if (c >= 3) check("fl_valid", 64'(wb_valid_o), 64'd0);
    end

    // Streaming on one channel: push and pop together at count 1
    for (int c = 0; c <= 3 + Lat; c++) begin
      next_cycle();
      wb_ready_i = 1'b1;
      if (c <= 2) drive(0, 32'h31 + 32'(c));
      settle();
      if (c - Lat >= 0 && c - Lat <= 2) check_wb("st", 0, 32'h31 + 32'(c - Lat));
      else check("st_idle", 64'(wb_valid_o), 64'd0);
    end

    // Single push into idle arbiter: bypass latency
    for (int c = 0; c <= 2; c++) begin
      next_cycle();
      wb_ready_i = 1'b1;
      if (c == 0) drive(3, 32'h77);
      settle();
      if (c == 0) check("byp_ready", 64'(fu_ready_o), 64'hf);
      if (c - Lat == 0) check_wb("byp", 3, 32'h77);
      else check("byp_idle", 64'(wb_valid_o), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
